dither_readback_tx: RTL
=======================

# dither_readback_tx

Outbound half of the MCU link. During the readback phase, this block accepts dithered pixels streamed out of the image SRAM and buffers them in a small FIFO. It frames the pixels as `sync byte, data bytes, XOR checksum` and sends them to the MCU over a byte-wide valid/ready channel. It sits between the SRAM read path and the MCU byte link, mirroring the inbound MCU_TX_RDY/store path.

## Interface
Parameters:
- `IMAGEX`, 64: image width in pixels.
- `IMAGEY`, 64: image height in pixels.
- `IMAGE_SIZE`, `IMAGEX*IMAGEY`: pixels per frame. Must be a multiple of 8.
- `IMAGE_ADDR_WIDTH`, `$clog2(IMAGE_SIZE)+1`: width of `pix_cnt`. It can hold the value `IMAGE_SIZE`.
- `RGB_SIZE`, 8: pixel word width.
- `FIFO_DEPTH`, 16: pixel FIFO entries. Must be a power of 2 and at least 2.
- `SYNC_BYTE`, 8'hA5: first byte of every frame.

Ports:
- `clk`, in, 1: the single clock. Everything is posedge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: one-cycle pulse that opens a frame. Ignored unless the FSM is in IDLE.
- `pix_data`, in, `RGB_SIZE`: pixel from the SRAM read path.
- `pix_valid`, in, 1: `pix_data` is valid.
- `pix_ready`, out, 1: the block accepts the pixel this cycle.
- `tx_data`, out, 8: byte to the MCU. Registered.
- `tx_valid`, out, 1: `tx_data` is valid. Registered.
- `tx_ready`, in, 1: the MCU accepts the byte.
- `busy`, out, 1: high whenever the FSM is not in IDLE.
- `frame_done`, out, 1: one-cycle pulse when the checksum byte is accepted.
- `pix_err`, out, 1: sticky error flag. Set when a pixel is offered while it cannot be accepted in IDLE. Cleared on an accepted `start`.
- `pix_cnt`, out, `IMAGE_ADDR_WIDTH`: number of pixels accepted in the current frame.

## Operation
- FSM states: IDLE, SYNC, STREAM, CSUM, DONE.
- IDLE:
  - `pix_ready`=0.
  - `start` clears `pix_cnt`, the checksum, the FIFO and `pix_err`, then moves to SYNC.
- SYNC:
  - Loads `tx_data`=`SYNC_BYTE` and holds `tx_valid`=1.
  - Moves to STREAM when `tx_valid && tx_ready`.
  - Pixels may already be accepted into the FIFO in this state.
- Pixel accept:
  - `pix_ready` = `busy && !fifo_full && (pix_cnt < IMAGE_SIZE)`.
  - On `pix_valid && pix_ready`: push the pixel and increment `pix_cnt`.
- STREAM:
  - Pops the FIFO into the output byte register whenever the register is empty or being accepted this cycle.
  - Each data byte sent is XORed into the 8-bit checksum.
  - Moves to CSUM once all data bytes have been accepted: `IMAGE_SIZE` bytes unpacked, `IMAGE_SIZE/8` bytes packed.
- CSUM:
  - Presents the checksum byte.
  - On acceptance, pulses `frame_done` and moves to DONE.
- DONE: returns to IDLE on the next cycle.
- Data byte in unpacked mode: the low 8 bits of `pix_data`, zero-extended if `RGB_SIZE` is less than 8.
- FIFO behaviour:
  - Simultaneous push and pop while full: pop frees a slot, but the push is blocked because `pix_ready` is computed from the current full flag.
  - Simultaneous push and pop while empty: no bypass.
  - Pointers carry one extra bit to tell full from empty.
- Error flag: `pix_valid` while in IDLE sets `pix_err`. The pixel is dropped.
- Back-pressure: `tx_valid` stays high and `tx_data` stays stable until `tx_ready`. Only then does the next byte load.
- Reset: asserting `rst_n` low mid-frame aborts the frame immediately. The FIFO empties and the FSM returns to IDLE. No partial checksum is emitted.

## Timing
- Reset values: `pix_ready`=0, `tx_data`=8'h00, `tx_valid`=0, `busy`=0, `frame_done`=0, `pix_err`=0, `pix_cnt`=0.
- `start` at cycle N:
  - `busy`=1 and `tx_valid`=1 with `SYNC_BYTE` at N+1.
  - `pix_ready` can be 1 at N+1.
- Pixel latency: a pixel accepted at cycle M (FIFO empty, output register free, `tx_ready`=1) appears on `tx_data` at M+2.
- Throughput with `tx_ready` held at 1: one byte per cycle.
- `frame_done` is high for exactly the cycle after the checksum handshake. `busy` falls one cycle after that.

## Configuration
- `DITHER_TX_PACK_EN` defined:
  - Each pixel contributes one bit, `pix_data[RGB_SIZE-1]`.
  - 8 consecutive pixels form one byte; the first pixel of each group is bit 7.
  - A byte enters the FIFO after its 8th pixel. The FIFO stores bytes, `FIFO_DEPTH` entries.
  - Data length is `IMAGE_SIZE/8` bytes.
  - Latency is measured from the 8th pixel of the group.
- `DITHER_TX_PACK_EN` undefined:
  - One byte per pixel, as described above.

## Test plan
All scenarios use `IMAGEX`=`IMAGEY`=4, i.e. `IMAGE_SIZE`=16.
- Unpacked, `tx_ready`=1, pixels 0x00..0x0F back-to-back after `start` → bytes A5, 00..0F, then 00; `frame_done` 1 cycle; `pix_cnt`=16.
- Unpacked, `tx_ready` toggling 1/0 every cycle → same 18-byte sequence; `tx_data` stable throughout every stall; no byte lost or duplicated.
- `tx_ready`=0 for 40 cycles while pixels are offered → `pix_ready` drops after 16 accepted (`FIFO_DEPTH`=16) plus at most 1 in the output register; releasing gives the correct sequence.
- Packed, pixels alternating 0x80/0x00 → bytes A5, AA, AA, checksum 00.
- `pix_valid`=1 in IDLE → `pix_err`=1 and no `tx_valid`; a following `start` clears `pix_err`. Reset asserted mid-STREAM → all outputs at reset values; a new frame after reset is correct.

Source files
------------

// File: rtl/dither_readback_tx.sv
// Readback transmitter: buffers dithered pixels in a FIFO and frames them as sync, data, XOR checksum.
// Define DITHER_TX_PACK_EN to pack one bit per pixel (8 pixels per byte) instead of one byte per pixel.
module dither_readback_tx #(
  parameter int         IMAGEX           = 64,
  parameter int         IMAGEY           = 64,
  parameter int         IMAGE_SIZE       = IMAGEX * IMAGEY,
  parameter int         IMAGE_ADDR_WIDTH = $clog2(IMAGE_SIZE) + 1,
  parameter int         RGB_SIZE         = 8,
  parameter int         FIFO_DEPTH       = 16,
  parameter logic [7:0] SYNC_BYTE        = 8'hA5
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [RGB_SIZE-1:0]         pix_data,
  input  logic                        pix_valid,
  output logic                        pix_ready,
  output logic [7:0]                  tx_data,
  output logic                        tx_valid,
  input  logic                        tx_ready,
  output logic                        busy,
  output logic                        frame_done,
  output logic                        pix_err,
  output logic [IMAGE_ADDR_WIDTH-1:0] pix_cnt
);

  localparam int FAW   = $clog2(FIFO_DEPTH);
  localparam int EXT_W = (RGB_SIZE > 8) ? RGB_SIZE : 8;
`ifdef DITHER_TX_PACK_EN
  localparam int DATA_LEN = IMAGE_SIZE / 8;
`else
  localparam int DATA_LEN = IMAGE_SIZE;
`endif
  localparam logic [IMAGE_ADDR_WIDTH-1:0] LP_PIX_MAX   = IMAGE_ADDR_WIDTH'(IMAGE_SIZE);
  localparam logic [IMAGE_ADDR_WIDTH-1:0] LP_LAST_BYTE = IMAGE_ADDR_WIDTH'(DATA_LEN - 1);

  typedef enum logic [2:0] {S_IDLE, S_SYNC, S_STREAM, S_CSUM, S_DONE} state_t;

  state_t                        r_state;
  state_t                        w_next;
  logic [7:0]                    r_tx_data;
  logic                          r_tx_valid;
  logic [IMAGE_ADDR_WIDTH-1:0]   r_pix_cnt;
  logic [IMAGE_ADDR_WIDTH-1:0]   r_sent_cnt;
  logic                          r_pix_err;
  logic [7:0]                    r_csum;
  logic [FAW:0]                  r_wr_ptr;
  logic [FAW:0]                  r_rd_ptr;
  logic [7:0]                    r_mem [FIFO_DEPTH];

  logic                          w_start;
  logic                          w_fifo_full;
  logic                          w_fifo_empty;
  logic                          w_accept;
  logic                          w_push;
  logic [7:0]                    w_push_byte;
  logic                          w_pop;
  logic [7:0]                    w_fifo_out;
  logic                          w_tx_hs;
  logic                          w_out_free;
  logic                          w_last_acc;

  assign w_start      = (r_state == S_IDLE) && start;
  assign w_fifo_empty = (r_wr_ptr == r_rd_ptr);
  assign w_fifo_full  = (r_wr_ptr[FAW] != r_rd_ptr[FAW]) &&
                        (r_wr_ptr[FAW-1:0] == r_rd_ptr[FAW-1:0]);
  assign w_fifo_out   = r_mem[r_rd_ptr[FAW-1:0]];

  // Full flag is the registered one, so a pop never makes room for a same-cycle push.
  assign pix_ready    = busy && !w_fifo_full && (r_pix_cnt < LP_PIX_MAX);
  assign w_accept     = pix_valid && pix_ready;

  assign w_tx_hs      = r_tx_valid && tx_ready;
  assign w_out_free   = !r_tx_valid || tx_ready;
  assign w_pop        = ((r_state == S_SYNC) || (r_state == S_STREAM)) && !w_fifo_empty && w_out_free;
  assign w_last_acc   = (r_state == S_STREAM) && w_tx_hs && (r_sent_cnt == LP_LAST_BYTE);

`ifdef DITHER_TX_PACK_EN
  logic [6:0] r_pack_sh;
  logic [2:0] r_bit_cnt;

  assign w_push      = w_accept && (r_bit_cnt == 3'd7);
  assign w_push_byte = {r_pack_sh, pix_data[RGB_SIZE-1]};

  // First pixel of a group ends up in bit 7.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pack_sh <= '0;
      r_bit_cnt <= '0;
    end else if (w_start) begin
      r_pack_sh <= '0;
      r_bit_cnt <= '0;
    end else if (w_accept) begin
      r_pack_sh <= {r_pack_sh[5:0], pix_data[RGB_SIZE-1]};
      r_bit_cnt <= r_bit_cnt + 3'd1;
    end
  end
`else
  logic [EXT_W-1:0] w_pix_ext;

  assign w_pix_ext   = EXT_W'(pix_data);
  assign w_push      = w_accept;
  assign w_push_byte = w_pix_ext[7:0];
`endif

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[FAW-1:0]] <= w_push_byte;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (start) w_next = S_SYNC;
      S_SYNC:   if (w_tx_hs) w_next = S_STREAM;
      S_STREAM: if (w_last_acc) w_next = S_CSUM;
      S_CSUM:   if (w_tx_hs) w_next = S_DONE;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy       = (r_state != S_IDLE);
    frame_done = (r_state == S_DONE);
  end

  // Checksum is folded in as bytes enter the output register, so it is final once the last byte is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_data  <= 8'h00;
      r_tx_valid <= 1'b0;
      r_pix_cnt  <= '0;
      r_sent_cnt <= '0;
      r_pix_err  <= 1'b0;
      r_csum     <= 8'h00;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
    end else if (w_start) begin
      r_tx_data  <= SYNC_BYTE;
      r_tx_valid <= 1'b1;
      r_pix_cnt  <= '0;
      r_sent_cnt <= '0;
      r_pix_err  <= 1'b0;
      r_csum     <= 8'h00;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
    end else begin
      if ((r_state == S_IDLE) && pix_valid) r_pix_err <= 1'b1;
      if (w_accept) r_pix_cnt <= r_pix_cnt + 1'b1;
      if (w_push)   r_wr_ptr  <= r_wr_ptr + 1'b1;
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
        r_csum   <= r_csum ^ w_fifo_out;
      end
      if ((r_state == S_STREAM) && w_tx_hs) r_sent_cnt <= r_sent_cnt + 1'b1;

      if (w_pop) begin
        r_tx_data  <= w_fifo_out;
        r_tx_valid <= 1'b1;
      end else if (w_last_acc) begin
        r_tx_data  <= r_csum;
        r_tx_valid <= 1'b1;
      end else if (w_tx_hs) begin
        r_tx_valid <= 1'b0;
      end
    end
  end

  assign tx_data  = r_tx_data;
  assign tx_valid = r_tx_valid;
  assign pix_err  = r_pix_err;
  assign pix_cnt  = r_pix_cnt;

endmodule
